aes_job_arbiter: RTL
====================

Name: aes_job_arbiter

Overview:
- Two-requester round-robin scheduler sharing one KeyExpansion core, one Cipher core and one InvCipher core.
- Accepts encrypt or decrypt jobs, each carrying a key and one 128-bit block.
- Re-runs key expansion only when the granted key differs from the last expanded key.
- Sequences the enable handshakes and returns one result per job; a watchdog aborts hung jobs.

Parameters:
- Nk, 4: key length in 32-bit words; K = Nk*32 key bits.
- Nr, 10: round count; not used internally, passed through for consistency with the cores.
- TIMEOUT, 64: max cycles spent in KEXP or RUN before abort; must be at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  per-requester job request; held until that requester's rsp_valid.
- req_mode  in  2  per requester: 0 = encrypt, 1 = decrypt.
- req_key  in  2*K  requester i at [i*K +: K].
- req_data  in  256  requester i at [i*128 +: 128].
- gnt  out  2  one-hot grant; high from LOAD through RESP inclusive.
- rsp_valid  out  2  one-cycle pulse to the granted requester.
- rsp_data  out  128  result; valid with rsp_valid; holds its value until the next RESP.
- rsp_err  out  1  qualifies rsp_valid; 1 = timeout abort.
- busy  out  1  high whenever state is not IDLE.
- kex_en  out  1  one-cycle start pulse to KeyExpansion.
- kex_key  out  K  latched key.
- kex_done  in  1  expansion complete (level).
- enc_en  out  1  Cipher enable (level).
- dec_en  out  1  InvCipher enable (level).
- core_data  out  128  latched block to both cores.
- enc_done, dec_done  in  1 each  core completion.
- enc_out, dec_out  in  128 each  core results.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; key cache invalid; rr_last=1, so requester 0 wins the first tie; watchdog counter 0.
- States are IDLE, LOAD, KEXP, RUN and RESP.
- IDLE:
  - If any req bit is set, go to LOAD.
  - Winner: the sole requester, or on a tie the requester != rr_last.
- LOAD (1 cycle):
  - gnt[w]=1; latch mode, key and data of w into kex_key/core_data/mode_q.
  - rr_last<=w.
  - Next state is RUN if cache_valid && cache_key==key; otherwise KEXP.
- KEXP:
  - kex_en=1 only in the first KEXP cycle.
  - When kex_done=1 (sampled no earlier than the second KEXP cycle): cache_key<=kex_key, cache_valid<=1, go to RUN.
- RUN:
  - enc_en=1 if mode_q=0, else dec_en=1, held until the matching done is sampled high.
  - On the matching done, capture enc_out or dec_out into rsp_data; go to RESP and drop the enable in the same edge.
  - The non-matching done input is ignored.
- RESP (1 cycle): rsp_valid[w]=1, rsp_err as set; next state IDLE, and gnt clears entering IDLE.
- Watchdog:
  - Counter clears on entry to KEXP and to RUN, and increments each cycle in those states.
  - At count==TIMEOUT-1 without the awaited done: go to RESP with rsp_err=1, rsp_data=0, cache_valid<=0, enables dropped.
- Latency:
  - Cache hit: req sampled in IDLE at cycle N → LOAD N+1 → RUN N+2; if done arrives at cycle M, rsp_valid is at M+1.
  - Cache miss adds the KEXP residency time.
- Request handling:
  - A requester dropping req mid-job does not cancel the job; the response is still pulsed.
  - req inputs are sampled only in IDLE.
  - The granted requester's req must be low or ignored in the IDLE cycle after RESP; back-to-back re-requests from it are honoured only via round-robin.
- Two requests pending continuously are served alternately 0,1,0,1…
- No new grant while busy; requests wait, no loss.
- rst asserted mid-job: immediate return to reset values. The aborted job gets no response, and the cache is invalidated.

Test Plan:
- Single encrypt, cache empty: req[0], key 000102…0f, data 00112233…eeff, mode 0 → one kex_en pulse, then enc_en; rsp_valid[0] with rsp_data=69c4e0d8…c55a, rsp_err=0.
- Same key, decrypt: requester 1, mode 1, data 69c4e0d8…c55a → no kex_en; dec_en; rsp_data=00112233…eeff; rsp_valid 2 cycles + core latency after req.
- Simultaneous req=2'b11 right after reset → gnt=01 first, then 10; rsp_valid order [0] then [1]; second job re-expands only if its key differs.
- Stubbed core never asserts enc_done, TIMEOUT=8 → rsp_valid with rsp_err=1 exactly 8 RUN cycles after entry; next same-key job issues kex_en (cache invalidated).
- rst pulled low during KEXP → gnt, kex_en, enc_en, busy go to 0 asynchronously; after release, a same-key job performs expansion again.
- Continuous req=11 for 6 jobs → grants alternate 0,1,0,1,0,1; never two grants high; busy low only in IDLE cycles.

Source files
------------

// File: rtl/aes_job_arbiter_if.sv
// aes_job_arbiter_if
//   Bundles the requester-side and core-side signals of aes_job_arbiter.
//   master : the arbiter (drives grants, responses and core controls)
//   slave  : the environment (requesters plus KeyExpansion/Cipher/InvCipher)
// Signals
//   req/req_mode/req_key/req_data   two requester job inputs
//   gnt/rsp_valid/rsp_data/rsp_err  grant and per-job response
//   busy                            arbiter not idle
//   kex_en/kex_key/kex_done         KeyExpansion handshake
//   enc_en/dec_en/core_data         Cipher/InvCipher enables and block
//   enc_done/dec_done/enc_out/dec_out core completion and results
interface aes_job_arbiter_if #(
    parameter int Nk = 4
);
    localparam int K = Nk * 32;

    logic [1:0]     req;
    logic [1:0]     req_mode;
    logic [2*K-1:0] req_key;
    logic [255:0]   req_data;
    logic [1:0]     gnt;
    logic [1:0]     rsp_valid;
    logic [127:0]   rsp_data;
    logic           rsp_err;
    logic           busy;
    logic           kex_en;
    logic [K-1:0]   kex_key;
    logic           kex_done;
    logic           enc_en;
    logic           dec_en;
    logic [127:0]   core_data;
    logic           enc_done;
    logic           dec_done;
    logic [127:0]   enc_out;
    logic [127:0]   dec_out;

    modport master (
        input  req, req_mode, req_key, req_data,
        input  kex_done, enc_done, dec_done, enc_out, dec_out,
        output gnt, rsp_valid, rsp_data, rsp_err, busy,
        output kex_en, kex_key, enc_en, dec_en, core_data
    );

    modport slave (
        output req, req_mode, req_key, req_data,
        output kex_done, enc_done, dec_done, enc_out, dec_out,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy,
        input  kex_en, kex_key, enc_en, dec_en, core_data
    );
endinterface

// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter
//   Round-robin scheduler letting two requesters share one KeyExpansion,
//   one Cipher and one InvCipher core. Each job carries a key, a mode and
//   one 128-bit block. Key expansion is skipped when the granted key equals
//   the last successfully expanded key. A watchdog aborts a job that waits
//   too long in KEXP or RUN and answers it with rsp_err=1.
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  aes_job_arbiter_if.master (requesters, responses, core handshakes)
module aes_job_arbiter #(
    parameter int Nk      = 4,
    parameter int Nr      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    aes_job_arbiter_if.master   bus
);
    localparam int K    = Nk * 32;
    localparam int WD_W = $clog2(TIMEOUT);

    // Nr only has to be consistent with the cores; it is checked, not used.
    generate
        if (TIMEOUT < 2 || Nr < 1) begin : g_param_check
            $error("aes_job_arbiter: TIMEOUT must be >= 2 and Nr >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        KEXP = 3'd2,
        RUN  = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              win;
    logic              rr_last;
    logic              mode_q;
    logic              cache_valid;
    logic [K-1:0]      cache_key;
    logic [K-1:0]      kex_key_q;
    logic [127:0]      core_data_q;
    logic [127:0]      rsp_data_q;
    logic              rsp_err_q;
    logic [WD_W-1:0]   wd_cnt;

    logic              pick_w;
    logic [K-1:0]      sel_key;
    logic [127:0]      sel_data;
    logic              cache_hit;
    logic              kex_ok;
    logic              run_ok;
    logic              wd_expired;
    logic [1:0]        win_vec;

    // On a tie the requester that was not served last wins.
    assign pick_w    = (bus.req == 2'b10) ? 1'b1 :
                       (bus.req == 2'b11) ? ~rr_last : 1'b0;
    assign sel_key   = win ? bus.req_key[2*K-1:K] : bus.req_key[K-1:0];
    assign sel_data  = win ? bus.req_data[255:128] : bus.req_data[127:0];
    assign cache_hit = cache_valid && (cache_key == sel_key);
    // kex_done may still be high from the previous expansion during the
    // first KEXP cycle, so it is only trusted from the second cycle on.
    assign kex_ok     = (state == KEXP) && bus.kex_done && (wd_cnt != '0);
    assign run_ok     = mode_q ? bus.dec_done : bus.enc_done;
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign win_vec    = win ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (|bus.req) state_n = LOAD;
            LOAD: state_n = cache_hit ? RUN : KEXP;
            KEXP: begin
                if (kex_ok)          state_n = RUN;
                else if (wd_expired) state_n = RESP;
            end
            RUN:  if (run_ok || wd_expired) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: job latching, key cache, watchdog and response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win         <= 1'b0;
            rr_last     <= 1'b1;
            mode_q      <= 1'b0;
            cache_valid <= 1'b0;
            cache_key   <= '0;
            kex_key_q   <= '0;
            core_data_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            case (state)
                IDLE: if (|bus.req) win <= pick_w;
                LOAD: begin
                    mode_q      <= bus.req_mode[win];
                    kex_key_q   <= sel_key;
                    core_data_q <= sel_data;
                    rr_last     <= win;
                    rsp_err_q   <= 1'b0;
                    wd_cnt      <= '0;
                end
                KEXP: begin
                    if (kex_ok) begin
                        cache_key   <= kex_key_q;
                        cache_valid <= 1'b1;
                        wd_cnt      <= '0;
                    end else if (wd_expired) begin
                        cache_valid <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                RUN: begin
                    if (run_ok) begin
                        rsp_data_q <= mode_q ? bus.dec_out : bus.enc_out;
                    end else if (wd_expired) begin
                        cache_valid <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = (state != IDLE) ? win_vec : 2'b00;
    assign bus.rsp_valid = (state == RESP) ? win_vec : 2'b00;
    assign bus.rsp_err   = (state == RESP) && rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.kex_en    = (state == KEXP) && (wd_cnt == '0);
    assign bus.kex_key   = kex_key_q;
    assign bus.enc_en    = (state == RUN) && !mode_q;
    assign bus.dec_en    = (state == RUN) && mode_q;
    assign bus.core_data = core_data_q;
endmodule
